// File: rtl/timer_pkg.sv
// Shared register map and CTRL bit positions for the bus_timer slice.
package timer_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_RELOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT    = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_AR  = 1;
  localparam int unsigned CTRL_IE  = 2;
  localparam int unsigned CTRL_EXP = 15;

endpackage

// File: rtl/bus_timer_if.sv
// CPU-side register bus seen by the timer: select, direction, address, data.
interface bus_timer_if #(
  parameter int unsigned DSIZE = 16
);
  logic             cs_b;
  logic             rnw;
  logic [1:0]       a;
  logic [DSIZE-1:0] din;
  logic [DSIZE-1:0] dout;

  modport master (output cs_b, rnw, a, din, input dout);
  modport slave  (input cs_b, rnw, a, din, output dout);
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..prescale while enabled, one-cycle tick on the terminal count.
module timer_prescaler #(
  parameter int unsigned PSIZE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [PSIZE-1:0] prescale,
  output logic             tick
);

  logic [PSIZE-1:0] pcnt;

  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped interval timer: CTRL/RELOAD/COUNT/PRESCALE registers,
// down-counter with optional auto-reload and a registered active-low IRQ.
module bus_timer
  import timer_pkg::*;
#(
  parameter int unsigned      DSIZE      = 16,
  parameter int unsigned      PSIZE      = 16,
  parameter logic [DSIZE-1:0] RELOAD_RST = 16'hffff
) (
  input  logic            clk,
  input  logic            reset,
  bus_timer_if.slave      bus,
  output logic            irq_b
);

  logic             en, ar, ie, exp_flag;
  logic [DSIZE-1:0] reload, count;
  logic [PSIZE-1:0] prescale;
  logic             tick, tick_live, expire;
  logic             wr, wr_ctrl, wr_reload, wr_count, wr_pre;
  logic [DSIZE-1:0] ctrl_word;

  assign wr        = !bus.cs_b && !bus.rnw;
  assign wr_ctrl   = wr && (bus.a == REG_CTRL);
  assign wr_reload = wr && (bus.a == REG_RELOAD);
  assign wr_count  = wr && (bus.a == REG_COUNT);
  assign wr_pre    = wr && (bus.a == REG_PRESCALE);

  // A COUNT write, or a CTRL write that stops the timer, swallows a coincident tick.
  assign tick_live = tick && !wr_count && !(wr_ctrl && !bus.din[CTRL_EN]);
  assign expire    = tick_live && (count == '0);

  timer_prescaler #(.PSIZE(PSIZE)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clear    (wr_ctrl || wr_pre),
    .prescale (prescale),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      en       <= 1'b0;
      ar       <= 1'b0;
      ie       <= 1'b0;
      exp_flag <= 1'b0;
      reload   <= RELOAD_RST;
      count    <= RELOAD_RST;
      prescale <= '0;
      irq_b    <= 1'b1;
    end else begin
      if (wr_ctrl) begin
        en <= bus.din[CTRL_EN];
        ar <= bus.din[CTRL_AR];
        ie <= bus.din[CTRL_IE];
      end else if (expire && !ar) begin
        en <= 1'b0;
      end
      // Expiry set takes priority over a same-cycle write-1-to-clear.
      exp_flag <= (exp_flag && !(wr_ctrl && bus.din[CTRL_EXP])) || expire;

      if (wr_count) begin
        count <= bus.din;
      end else if (tick_live) begin
        if (count != '0) begin
          count <= count - 1'b1;
        end else if (ar) begin
          count <= reload;
        end
      end

      if (wr_reload) reload   <= bus.din;
      if (wr_pre)    prescale <= PSIZE'(bus.din);
      irq_b <= !(exp_flag && ie);
    end
  end

  always_comb begin
    ctrl_word           = '0;
    ctrl_word[CTRL_EN]  = en;
    ctrl_word[CTRL_AR]  = ar;
    ctrl_word[CTRL_IE]  = ie;
    ctrl_word[CTRL_EXP] = exp_flag;
  end

  always_comb begin
    bus.dout = '0;
    if (!bus.cs_b && bus.rnw) begin
      unique case (bus.a)
        REG_CTRL:     bus.dout = ctrl_word;
        REG_RELOAD:   bus.dout = reload;
        REG_COUNT:    bus.dout = count;
        REG_PRESCALE: bus.dout = DSIZE'(prescale);
        default:      bus.dout = '0;
      endcase
    end
  end

endmodule
